// File: rtl/alu_seq_param_if.sv
// Issue/result bundle for alu_seq_param: the controller drives start/mode/operands, the ALU returns results.
// Port ovf exists only when ALU_SEQ_OVF_EN is defined.
interface alu_seq_param_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [2:0]         mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   op1;
  logic [WIDTH-1:0]   op2;
  logic [2*WIDTH-1:0] op3;
  logic               done;
  logic               busy;
  logic               div_by_zero;
`ifdef ALU_SEQ_OVF_EN
  logic               ovf;
`endif

  modport master (
    output start, mode, a, b,
`ifdef ALU_SEQ_OVF_EN
    input  ovf,
`endif
    input  op1, op2, op3, done, busy, div_by_zero
  );

  modport slave (
    input  start, mode, a, b,
`ifdef ALU_SEQ_OVF_EN
    output ovf,
`endif
    output op1, op2, op3, done, busy, div_by_zero
  );
endinterface

// File: rtl/alu_seq_param.sv
// Multi-cycle parametrised ALU: single-cycle logic ops, shift-add MUL and restoring DIV over WIDTH steps.
// Optional signed-overflow output enabled by defining ALU_SEQ_OVF_EN.
module alu_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  alu_seq_param_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] MODE_ADD = 3'b000;
  localparam logic [2:0] MODE_SUB = 3'b001;
  localparam logic [2:0] MODE_AND = 3'b010;
  localparam logic [2:0] MODE_OR  = 3'b011;
  localparam logic [2:0] MODE_MUL = 3'b100;
  localparam logic [2:0] MODE_DIV = 3'b101;
  localparam logic [2:0] MODE_XOR = 3'b110;
  localparam logic [2:0] MODE_CMP = 3'b111;

  typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

  state_t             state_reg, state_next;
  logic               accept;

  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [2:0]         mode_reg;
  logic [CW-1:0]      cnt_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic [WIDTH-1:0]   hi_next, lo_next;

  logic [WIDTH-1:0]   op1_reg, op2_reg;
  logic [2*WIDTH-1:0] op3_reg;
  logic               done_reg, dbz_reg;

  logic [WIDTH-1:0]   res_op1, res_op2;
  logic [2*WIDTH-1:0] res_op3;
  logic               res_dbz;

  logic [WIDTH:0]     add_sum, sub_diff, mul_sum, div_trial, div_diff;

  // ---------------- FSM state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // ---------------- FSM next state ----------------
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          accept = 1'b1;
          if (bus.mode == MODE_MUL || (bus.mode == MODE_DIV && bus.b != '0))
            state_next = ITER;
          else
            state_next = FIN;
        end
      end
      ITER:    if (cnt_reg == CW'(WIDTH - 1)) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- one MUL / DIV iteration ----------------
  // hi/lo hold {partial product, multiplier} for MUL and {remainder, dividend->quotient} for DIV.
  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : '0);
    div_trial = {hi_reg, lo_reg[WIDTH-1]};
    div_diff  = div_trial - {1'b0, b_reg};
    hi_next   = hi_reg;
    lo_next   = lo_reg;
    if (mode_reg == MODE_MUL) begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      hi_next = div_diff[WIDTH-1:0];
      lo_next = {lo_reg[WIDTH-2:0], 1'b1};
    end else begin
      hi_next = div_trial[WIDTH-1:0];
      lo_next = {lo_reg[WIDTH-2:0], 1'b0};
    end
  end

  // ---------------- result selection ----------------
  always_comb begin
    add_sum  = {1'b0, a_reg} + {1'b0, b_reg};
    sub_diff = {1'b0, a_reg} - {1'b0, b_reg};
    res_op1  = '0;
    res_op2  = '0;
    res_op3  = '0;
    res_dbz  = 1'b0;
    case (mode_reg)
      MODE_ADD: begin
        res_op1    = add_sum[WIDTH-1:0];
        res_op2[0] = add_sum[WIDTH];
        res_op3    = {{(WIDTH-1){1'b0}}, add_sum};
      end
      MODE_SUB: begin
        res_op1    = sub_diff[WIDTH-1:0];
        res_op2[0] = sub_diff[WIDTH];
        res_op3    = {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
      end
      MODE_AND: begin
        res_op1 = a_reg & b_reg;
        res_op3 = {{WIDTH{1'b0}}, res_op1};
      end
      MODE_OR: begin
        res_op1 = a_reg | b_reg;
        res_op3 = {{WIDTH{1'b0}}, res_op1};
      end
      MODE_XOR: begin
        res_op1 = a_reg ^ b_reg;
        res_op3 = {{WIDTH{1'b0}}, res_op1};
      end
      MODE_MUL: begin
        res_op1 = lo_reg;
        res_op2 = hi_reg;
        res_op3 = {hi_reg, lo_reg};
      end
      MODE_DIV: begin
        if (b_reg == '0) begin
          res_op1 = '1;
          res_op2 = a_reg;
          res_op3 = {a_reg, {WIDTH{1'b1}}};
          res_dbz = 1'b1;
        end else begin
          res_op1 = lo_reg;
          res_op2 = hi_reg;
          res_op3 = {hi_reg, lo_reg};
        end
      end
      MODE_CMP: begin
        res_op1      = (a_reg > b_reg) ? a_reg : b_reg;
        res_op2[2:0] = {a_reg > b_reg, a_reg == b_reg, a_reg < b_reg};
        res_op3      = {{WIDTH{1'b0}}, res_op1};
      end
      default: ;
    endcase
  end

  // ---------------- datapath and result registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      mode_reg <= '0;
      cnt_reg  <= '0;
      hi_reg   <= '0;
      lo_reg   <= '0;
      op1_reg  <= '0;
      op2_reg  <= '0;
      op3_reg  <= '0;
      done_reg <= 1'b0;
      dbz_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        a_reg    <= bus.a;
        b_reg    <= bus.b;
        mode_reg <= bus.mode;
        cnt_reg  <= '0;
        hi_reg   <= '0;
        lo_reg   <= (bus.mode == MODE_MUL) ? bus.b : bus.a;
      end
      if (state_reg == ITER) begin
        cnt_reg <= cnt_reg + CW'(1);
        hi_reg  <= hi_next;
        lo_reg  <= lo_next;
      end
      if (state_reg == FIN) begin
        done_reg <= 1'b1;
        op1_reg  <= res_op1;
        op2_reg  <= res_op2;
        op3_reg  <= res_op3;
        dbz_reg  <= res_dbz;
      end
    end
  end

`ifdef ALU_SEQ_OVF_EN
  logic ovf_reg, res_ovf;

  // Signed overflow: operands' sign bits vs. result sign bit.
  always_comb begin
    res_ovf = 1'b0;
    case (mode_reg)
      MODE_ADD: res_ovf = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (add_sum[WIDTH-1] != a_reg[WIDTH-1]);
      MODE_SUB: res_ovf = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (sub_diff[WIDTH-1] != a_reg[WIDTH-1]);
      MODE_MUL: res_ovf = (hi_reg != '0);
      default:  res_ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                    ovf_reg <= 1'b0;
    else if (state_reg == FIN)  ovf_reg <= res_ovf;
  end

  assign bus.ovf = ovf_reg;
`endif

  assign bus.op1         = op1_reg;
  assign bus.op2         = op2_reg;
  assign bus.op3         = op3_reg;
  assign bus.done        = done_reg;
  assign bus.busy        = (state_reg != IDLE);
  assign bus.div_by_zero = dbz_reg;
endmodule

// File: doc/alu_seq_param.md
Name: alu_seq_param

Overview:
- Parametrised, multi-cycle successor to the 8-bit ALU.
- Operand width is set by WIDTH.
- Adds a start/busy/done handshake, a registered result hold, iterative shift-add multiply and restoring divide, unsigned compare, and divide-by-zero detection.
- Sits in the datapath as the shared arithmetic unit; the controller issues one operation at a time and waits for done.

Parameters:
- WIDTH, 8, operand width in bits (legal range 4 to 32); also the iteration count for MUL and DIV.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to issue an operation; sampled only when busy=0.
- mode  input  3  operation select, latched with the operands.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- op1  output  WIDTH  primary result.
- op2  output  WIDTH  secondary result (carry, borrow, high product, remainder, or flags).
- op3  output  2*WIDTH  wide result.
- done  output  1  one-cycle pulse; results valid.
- busy  output  1  an operation is in flight.
- div_by_zero  output  1  the last DIV had b=0; held with the results.

Behaviour:
- Reset: one clock with rst=1 gives state=IDLE, op1=0, op2=0, op3=0, done=0, busy=0, div_by_zero=0, and clears all internal registers.
- Reset overrides start and aborts any operation in progress; no done is produced for the aborted operation.
- FSM states: IDLE, ITER, FIN.
  - IDLE → FIN when start=1 and mode is not MUL/DIV.
  - IDLE → ITER when start=1 and mode is MUL or DIV with b≠0.
  - IDLE → FIN when start=1, mode=DIV and b=0.
  - ITER → FIN after WIDTH iterations.
  - FIN → IDLE unconditionally; done=1 in the cycle after FIN.
- Acceptance: start=1 at edge E0 while busy=0 latches a, b and mode, and sets busy=1.
  - start while busy=1 is ignored; no queueing.
  - start during the done cycle is accepted, so back-to-back issue is possible.
- Latency, measured from the accept edge E0 to the edge that sets done=1:
  - 1 cycle for single-cycle modes and for DIV with b=0.
  - WIDTH+1 cycles for MUL/DIV.
- busy=0 and done=1 in the same cycle; done stays high for exactly one cycle.
- op1, op2, op3 and div_by_zero update only on the done edge and hold until the next done or rst.
- Unused result bits are 0.
- Modes (a and b are the latched values):
  - 000 ADD: op1 = (a+b) mod 2^WIDTH; op2 = carry-out in bit 0; op3 = zero-extended (WIDTH+1)-bit sum.
  - 001 SUB: op1 = (a-b) mod 2^WIDTH; op2[0] = borrow (a<b); op3 = zero-extended op1.
  - 010 AND, 011 OR, 110 XOR: op1 = bitwise result; op2 = 0; op3 = zero-extended op1.
  - 100 MUL: shift-add over WIDTH iterations; op3 = a*b (full 2*WIDTH bits); op1 = op3[WIDTH-1:0]; op2 = op3[2*WIDTH-1:WIDTH].
  - 101 DIV: restoring division over WIDTH iterations; op1 = quotient; op2 = remainder; op3 = {remainder, quotient}.
    - If b=0: op1 = all ones, op2 = a, op3 = {a, all ones}, div_by_zero=1.
    - div_by_zero=0 for every other completed operation.
  - 111 CMP: op1 = max(a,b); op2[2:0] = {a>b, a==b, a<b}; op3 = zero-extended op1.
- Operands and mode may change freely after acceptance without affecting the operation in flight.

Optional Feature:
- Macro: ALU_SEQ_OVF_EN.
- When defined: adds output port ovf (1 bit), updated on the done edge, reset 0.
  - ADD/SUB: signed two's-complement overflow of op1.
  - MUL: 1 when op2≠0.
  - All other modes: 0.
- When undefined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, mode=100, a=3, b=2, start one cycle → done exactly 9 cycles after accept; op3=16'd6, op1=6, op2=0, busy high for 9 cycles, done high for 1.
- mode=000, a=255, b=1 → done 1 cycle after accept; op1=0, op2=1, op3=256. Then mode=001, a=2, b=5 → op1=253, op2=1.
- mode=101, a=200, b=7 → op1=28, op2=4, div_by_zero=0 after 9 cycles. Then a=200, b=0 → done after 1 cycle; op1=255, op2=200, div_by_zero=1.
- MUL with a=15, b=15 in flight; pulse start with mode=000 at cycle 3 → ignored; op3=225 at done; no second done.
- rst=1 at cycle 4 of a DIV → next cycle all outputs 0 and busy=0; no done. A new start with mode=111, a=9, b=9 → op1=9, op2=3'b010.
- WIDTH=16 with ALU_SEQ_OVF_EN defined: mode=000, a=16'h7FFF, b=1 → op1=16'h8000, ovf=1. Then MUL with a=16'h0100, b=16'h0100 → op3=32'h00010000, op2=1, ovf=1, latency 17.
